// File: rtl/dl_mem_arbiter.sv
// rtl/dl_mem_arbiter.sv - download/core arbiter for one external memory request port
//
// Download writes (ioctl_*) are buffered in a small FIFO and have strict
// priority. The core requester is serviced only when no download is active
// and the FIFO is empty.
// Ports:
//   clk_memory, reset_n          clock, async active-low reset
//   ioctl_download/wr/addr/data  download write stream
//   core_req/we/addr/wdata       core request (held until core_ack)
//   core_ack, core_rdata         core completion pulse and read data
//   mem_req/we/addr/wdata        memory request (held until mem_ack)
//   mem_rdata, mem_ack           memory response
//   dl_busy, dl_done             download activity / retirement pulse
//   fifo_overflow                sticky dropped-write flag
module dl_mem_arbiter #(
    parameter int AW         = 27,
    parameter int DW         = 16,
    parameter int FIFO_DEPTH = 8
) (
    input  logic          clk_memory,
    input  logic          reset_n,
    input  logic          ioctl_download,
    input  logic          ioctl_wr,
    input  logic [AW-1:0] ioctl_addr,
    input  logic [DW-1:0] ioctl_data,
    input  logic          core_req,
    input  logic          core_we,
    input  logic [AW-1:0] core_addr,
    input  logic [DW-1:0] core_wdata,
    output logic          core_ack,
    output logic [DW-1:0] core_rdata,
    output logic          mem_req,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    input  logic          mem_ack,
    output logic          dl_busy,
    output logic          dl_done,
    output logic          fifo_overflow
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DL_ISSUE,
        ST_CORE_ISSUE
    } state_t;

    state_t state_q, state_d;

    logic [AW+DW-1:0] fifo_mem [FIFO_DEPTH];
    logic [PW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]    count_q, count_d;
    logic             fifo_empty, fifo_full;
    logic             fifo_push, fifo_pop, fifo_drop;
    logic [AW-1:0]    head_addr;
    logic [DW-1:0]    head_data;

    logic          mem_req_q, mem_req_d;
    logic          mem_we_q, mem_we_d;
    logic [AW-1:0] mem_addr_q, mem_addr_d;
    logic [DW-1:0] mem_wdata_q, mem_wdata_d;
    logic          core_ack_q, core_ack_d;
    logic [DW-1:0] core_rdata_q, core_rdata_d;
    logic          dl_seen_q, dl_seen_d;
    logic          dl_done_q, dl_done_d;
    logic          overflow_q, overflow_d;
    logic          dl_prev_q;
    logic          dl_rise;

    assign fifo_empty = (count_q == '0);
    assign fifo_full  = (count_q == CW'(FIFO_DEPTH));
    assign fifo_pop   = (state_q == ST_IDLE) && !fifo_empty;
    // A pop in the same cycle frees the slot, so a write into a full FIFO still lands.
    assign fifo_push  = ioctl_wr && (!fifo_full || fifo_pop);
    assign fifo_drop  = ioctl_wr && fifo_full && !fifo_pop;
    assign head_addr  = fifo_mem[rd_ptr_q][AW+DW-1:DW];
    assign head_data  = fifo_mem[rd_ptr_q][DW-1:0];
    assign dl_rise    = ioctl_download && !dl_prev_q;

    always_comb begin
        count_d = count_q;
        case ({fifo_push, fifo_pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // Storage needs no reset; occupancy is tracked by the pointers and count.
    always_ff @(posedge clk_memory) begin
        if (fifo_push) begin
            fifo_mem[wr_ptr_q] <= {ioctl_addr, ioctl_data};
        end
    end

    always_comb begin
        state_d      = state_q;
        mem_req_d    = mem_req_q;
        mem_we_d     = mem_we_q;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        core_rdata_d = core_rdata_q;
        core_ack_d   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    mem_addr_d  = head_addr;
                    mem_wdata_d = head_data;
                    mem_we_d    = 1'b1;
                    mem_req_d   = 1'b1;
                    state_d     = ST_DL_ISSUE;
                // core_req is still high in the cycle core_ack pulses; skipping
                // that cycle keeps a finished request from being issued twice.
                end else if (!ioctl_download && core_req && !core_ack_q) begin
                    mem_addr_d  = core_addr;
                    mem_wdata_d = core_wdata;
                    mem_we_d    = core_we;
                    mem_req_d   = 1'b1;
                    state_d     = ST_CORE_ISSUE;
                end
            end
            ST_DL_ISSUE: begin
                if (mem_ack) begin
                    mem_req_d = 1'b0;
                    mem_we_d  = 1'b0;
                    state_d   = ST_IDLE;
                end
            end
            ST_CORE_ISSUE: begin
                if (mem_ack) begin
                    if (!mem_we_q) begin
                        core_rdata_d = mem_rdata;
                    end
                    core_ack_d = 1'b1;
                    mem_req_d  = 1'b0;
                    mem_we_d   = 1'b0;
                    state_d    = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        dl_done_d  = dl_seen_q && !ioctl_download && fifo_empty && (state_q == ST_IDLE);
        dl_seen_d  = ioctl_download || (dl_seen_q && !dl_done_d);
        overflow_d = (dl_rise ? 1'b0 : overflow_q) || fifo_drop;
    end

    always_ff @(posedge clk_memory or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= ST_IDLE;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            mem_req_q    <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            core_ack_q   <= 1'b0;
            core_rdata_q <= '0;
            dl_seen_q    <= 1'b0;
            dl_done_q    <= 1'b0;
            overflow_q   <= 1'b0;
            dl_prev_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            if (fifo_push) wr_ptr_q <= wr_ptr_q + PW'(1);
            if (fifo_pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
            count_q      <= count_d;
            mem_req_q    <= mem_req_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            core_ack_q   <= core_ack_d;
            core_rdata_q <= core_rdata_d;
            dl_seen_q    <= dl_seen_d;
            dl_done_q    <= dl_done_d;
            overflow_q   <= overflow_d;
            dl_prev_q    <= ioctl_download;
        end
    end

    assign mem_req       = mem_req_q;
    assign mem_we        = mem_we_q;
    assign mem_addr      = mem_addr_q;
    assign mem_wdata     = mem_wdata_q;
    assign core_ack      = core_ack_q;
    assign core_rdata    = core_rdata_q;
    assign dl_done       = dl_done_q;
    assign fifo_overflow = overflow_q;
    assign dl_busy       = ioctl_download || !fifo_empty || (state_q == ST_DL_ISSUE);

endmodule

// File: doc/dl_mem_arbiter.md
# dl_mem_arbiter

Shares one external memory request port between the APF download write stream (`ioctl_wr`/`ioctl_addr`/`ioctl_data` from the data I/O block) and a core-side read/write requester. A small FIFO absorbs download writes while a memory transaction is in flight. The download has strict priority: the core is serviced only when no download is active and the FIFO is drained. Sits in the `clk_memory` domain between the data I/O block and the SDRAM/BRAM controller.

## Interface
Parameters:
- `AW`, 27, address width (download and memory side)
- `DW`, 16, data width (8 or 16)
- `FIFO_DEPTH`, 8, download FIFO entries; power of two, at least 2

Ports:
- `clk_memory`  in  1  sole clock; all logic rising-edge
- `reset_n`  in  1  asynchronous, active-low reset
- `ioctl_download`  in  1  download active (already synchronised to `clk_memory`)
- `ioctl_wr`  in  1  one-cycle write strobe
- `ioctl_addr`  in  AW  download write address
- `ioctl_data`  in  DW  download write data
- `core_req`  in  1  core request; held high until `core_ack`
- `core_we`  in  1  1 = write, 0 = read
- `core_addr`  in  AW  core address
- `core_wdata`  in  DW  core write data
- `core_ack`  out  1  one-cycle completion pulse
- `core_rdata`  out  DW  read data, valid from `core_ack` until the next core completion
- `mem_req`  out  1  memory request, held until `mem_ack`
- `mem_we`  out  1  memory write enable
- `mem_addr`  out  AW  memory address
- `mem_wdata`  out  DW  memory write data
- `mem_rdata`  in  DW  memory read data, valid with `mem_ack`
- `mem_ack`  in  1  one-cycle completion from memory; ignored while `mem_req` is low
- `dl_busy`  out  1  download active, FIFO non-empty, or a download transaction in flight
- `dl_done`  out  1  one-cycle pulse when a download has fully retired to memory
- `fifo_overflow`  out  1  sticky flag: a download write was dropped

## Operation
- FIFO push: every cycle `ioctl_wr`=1, regardless of `ioctl_download`.
  - When the FIFO is full and no pop happens in the same cycle, the write is dropped and `fifo_overflow` is set.
  - A simultaneous push and pop on a full FIFO succeeds.
  - `fifo_overflow` clears on the rising edge of `ioctl_download` and on reset.
- FSM states:
  - **IDLE**
    - FIFO non-empty: pop the head, load `mem_addr`/`mem_wdata`, `mem_we`=1, `mem_req`=1, go to DL_ISSUE.
    - FIFO empty, `ioctl_download`=0 and `core_req`=1: load the core fields, `mem_req`=1, go to CORE_ISSUE.
    - Otherwise stay in IDLE.
  - **DL_ISSUE**: hold all `mem_*` outputs stable. On `mem_ack`: `mem_req`=0, `mem_we`=0, go to IDLE.
  - **CORE_ISSUE**: hold all `mem_*` outputs stable. On `mem_ack`: capture `mem_rdata` into `core_rdata` (reads only; writes leave it unchanged), pulse `core_ack` next cycle, `mem_req`=0, go to IDLE.
- A core transaction already in CORE_ISSUE completes even if `ioctl_download` rises. Download entries wait in the FIFO meanwhile.
- Core requests stall indefinitely while `ioctl_download`=1 or the FIFO is non-empty.
- `dl_done` logic:
  - An internal `dl_seen` flag sets when `ioctl_download`=1.
  - `dl_done` pulses for one cycle when `dl_seen`=1, `ioctl_download`=0, the FIFO is empty and the state is IDLE. `dl_seen` clears in the same cycle.
- `dl_busy` is combinational: `ioctl_download` | FIFO non-empty | (state == DL_ISSUE).

## Timing
- Reset values: state IDLE, FIFO empty, `mem_req`/`mem_we`/`core_ack`/`dl_done`/`fifo_overflow`=0, `mem_addr`/`mem_wdata`/`core_rdata`=0, `dl_seen`=0.
- Reset asserted mid-transaction abandons it immediately; the memory controller must tolerate `mem_req` dropping before `mem_ack`.
- Download latency: `ioctl_wr` in cycle 0 → `mem_req` high in cycle 2 (FIFO registered, FSM decides in cycle 1).
- Completion: `mem_ack` in cycle k → `mem_req` low in k+1 (FSM in IDLE) → next request can be high in k+2.
- Core latency: `core_req` rising in cycle 0 (IDLE, eligible) → `mem_req` high in cycle 1; `mem_ack` in k → `core_ack` high in k+1 only. The requester drops `core_req` in k+2 or later; the FSM re-samples it only in IDLE.
- `mem_ack` arriving in IDLE is ignored.
- FIFO occupancy uses a `$clog2(FIFO_DEPTH)+1`-bit count. Read and write pointers wrap modulo `FIFO_DEPTH`.

## Test plan
- **Single download write:** reset, `ioctl_download`=1, one `ioctl_wr` (addr 0x100, data 0xBEEF) in cycle 0, `mem_ack` in cycle 4 → `mem_req`/`mem_we` high in cycles 2–4 with addr 0x100, data 0xBEEF; `mem_req` low in cycle 5.
- **Full FIFO and overflow:** 10 back-to-back `ioctl_wr` (data 0..9), `mem_ack` withheld → writes 0–8 retire in order (one in flight plus 8 queued), write 9 dropped, `fifo_overflow`=1 until the next `ioctl_download` rise.
- **Priority:** `core_req` read held high while a 3-write download is active → no core transaction until `ioctl_download`=0 and all 3 retired. Then `mem_we`=0, and with `mem_rdata`=0x1234 on `mem_ack`, `core_ack` pulses one cycle and `core_rdata`=0x1234.
- **Download rises during a core write:** `ioctl_download` rises while CORE_ISSUE waits → core write completes first, then the FIFO drains. `dl_done` pulses exactly once, after the last download `mem_ack` and after `ioctl_download` falls.
- **Reset mid-transaction:** assert `reset_n`=0 during DL_ISSUE with 4 entries queued → all outputs go to their reset values asynchronously. After release, no stale entry is issued and `dl_busy`=0.
